// File: rtl/aes_dec_sequencer.sv
// Block sequencer for the AES-128 decryption core: fetches ciphertext, issues it, waits for the core.
// Optional core watchdog enabled by defining SEQ_TIMEOUT_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef TEXT_WIDTH
`define TEXT_WIDTH 128
`endif

module aes_dec_sequencer #(
    parameter int ADDR_WIDTH     = `ADDR_WIDTH,
    parameter int TEXT_WIDTH     = `TEXT_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   block_count_i,
    output logic                  cipher_rd_o,
    output logic [ADDR_WIDTH-1:0] cipher_addr_o,
    input  logic [TEXT_WIDTH-1:0] cipher_data_i,
    output logic                  core_valid_o,
    input  logic                  core_ready_i,
    output logic [TEXT_WIDTH-1:0] ciphertext_o,
    input  logic                  core_done_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    // state       | meaning
    // S_IDLE      | waiting for start_i
    // S_FETCH     | ciphertext read strobe for address pc
    // S_WAIT_RD   | read data returns, captured into ciphertext_o
    // S_ISSUE     | block offered to the core until ready
    // S_WAIT_CORE | waiting for the core finish pulse
    // S_NEXT      | last-block test / address advance
    // S_DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_RD, S_ISSUE, S_WAIT_CORE, S_NEXT, S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_ONE  = ADDR_WIDTH'(1);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  r_state;
    logic [ADDR_WIDTH:0]     r_count;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [TEXT_WIDTH-1:0]   r_ct;
    logic                    r_rd;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_last;

    // count is one bit wider than pc so that a full 2^ADDR_WIDTH run still terminates
    assign w_last = ({1'b0, r_pc} == (r_count - CNT_ONE));

`ifdef SEQ_TIMEOUT_EN
    localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    logic [TMR_W-1:0] r_tmr;
    logic             r_err;
    assign error_o = r_err;
`else
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_pc    <= '0;
            r_ct    <= '0;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_tmr   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_count <= block_count_i;
                        r_pc    <= '0;
                        r_busy  <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        if (block_count_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                            r_rd    <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    r_ct    <= cipher_data_i;
                    r_state <= S_ISSUE;
                    r_valid <= 1'b1;
                end
                S_ISSUE: begin
                    if (core_ready_i) begin
                        r_state <= S_WAIT_CORE;
`ifdef SEQ_TIMEOUT_EN
                        r_tmr   <= TMR_LOAD;
`endif
                    end else begin
                        r_valid <= 1'b1;
                    end
                end
                S_WAIT_CORE: begin
                    if (core_done_i) begin
                        r_state <= S_NEXT;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_tmr == '0) begin
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmr <= r_tmr - TMR_ONE;
                    end
`endif
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_pc    <= r_pc + PC_ONE;
                        r_state <= S_FETCH;
                        r_rd    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cipher_rd_o   = r_rd;
    assign cipher_addr_o = r_pc;
    assign core_valid_o  = r_valid;
    assign ciphertext_o  = r_ct;
    assign pc_o          = r_pc;
    assign busy_o        = r_busy;
    assign done_o        = r_done;

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Randomized bench for aes_dec_sequencer: memory, core model and run-level reference checks.
// Watchdog scenario is exercised when SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module tb_aes_dec_sequencer;

    localparam int AW = 4;
    localparam int TW = 128;
    localparam int TO = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW:0]   block_count_i;
    logic          cipher_rd_o;
    logic [AW-1:0] cipher_addr_o;
    logic [TW-1:0] cipher_data_i;
    logic          core_valid_o;
    logic          core_ready_i;
    logic [TW-1:0] ciphertext_o;
    logic          core_done_i;
    logic [AW-1:0] pc_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    aes_dec_sequencer #(.ADDR_WIDTH(AW), .TEXT_WIDTH(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .block_count_i(block_count_i),
        .cipher_rd_o(cipher_rd_o), .cipher_addr_o(cipher_addr_o), .cipher_data_i(cipher_data_i),
        .core_valid_o(core_valid_o), .core_ready_i(core_ready_i), .ciphertext_o(ciphertext_o),
        .core_done_i(core_done_i), .pc_o(pc_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [TW-1:0] mem [1 << AW];
    logic [TW-1:0] hs_q [$];
    int            pc_q [$];
    int            cyc = 0;
    int            rd_cnt, done_cnt, first_valid_cyc, first_rd_cyc, done_cyc;
    int            last_done_cyc, hs_cyc;
    int            ready_pct = 100;
    int            lat_min = 10, lat_max = 10;
    bit            spur_en = 0, stall_en = 0, core_never = 0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // ciphertext memory: data valid in the cycle after the read strobe, junk otherwise
    initial begin
        bit            rd_pend = 0;
        logic [AW-1:0] rd_addr = '0;
        cipher_data_i = '0;
        forever begin
            @(negedge clk_i);
            cipher_data_i = rd_pend ? mem[rd_addr] : {$urandom, $urandom, $urandom, $urandom};
            rd_pend = cipher_rd_o;
            rd_addr = cipher_addr_o;
        end
    end

    // decryption core model: ready policy, finish latency, optional spurious finish pulses
    initial begin
        int            cd = 0;
        int            stall_left = 0;
        int            stall_cyc = 0;
        bit            stall_armed = 0;
        logic [TW-1:0] stall_ct = '0;
        core_ready_i = 1'b0;
        core_done_i  = 1'b0;
        forever begin
            @(negedge clk_i);
            core_done_i = 1'b0;
            if (!rst_ni) begin
                cd = 0;
                stall_armed = 0;
                core_ready_i = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        core_done_i = 1'b1;
                        pc_q.push_back(int'(pc_o));
                        last_done_cyc = cyc;
                    end
                end
                if (core_valid_o) begin
                    if (stall_en) begin
                        if (!stall_armed) begin
                            stall_armed = 1;
                            stall_left = 5;
                            stall_ct = ciphertext_o;
                            stall_cyc = cyc;
                        end else if (stall_left > 0) begin
                            chk("stall_ct_stable", ciphertext_o, stall_ct);
                        end
                        if (stall_left > 0) begin
                            core_ready_i = 1'b0;
                            stall_left--;
                        end else begin
                            core_ready_i = 1'b1;
                            chk("stall_hs_cycle", cyc, stall_cyc + 5);
                        end
                    end else begin
                        core_ready_i = ($urandom_range(0, 99) < ready_pct);
                    end
                    if (spur_en && !core_done_i && $urandom_range(0, 2) == 0)
                        core_done_i = 1'b1;
                    if (core_ready_i) begin
                        hs_q.push_back(ciphertext_o);
                        hs_cyc = cyc;
                        stall_armed = 0;
                        if (!core_never) cd = $urandom_range(lat_min, lat_max);
                    end
                end else begin
                    core_ready_i = $urandom_range(0, 1) != 0;
                end
            end
        end
    end

    // run monitor: read address order, first activity cycles, completion pulses
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            if (cipher_rd_o) begin
                chk("rd_addr", cipher_addr_o, rd_cnt);
                chk("rd_addr_eq_pc", cipher_addr_o, pc_o);
                if (rd_cnt == 0) first_rd_cyc = cyc;
                rd_cnt++;
            end
            if (core_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_run();
        hs_q.delete();
        pc_q.delete();
        rd_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        first_rd_cyc = -1;
        done_cyc = -1;
        last_done_cyc = -1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"}, cipher_rd_o, 1'b0);
        chk({tag, "_addr"}, cipher_addr_o, '0);
        chk({tag, "_valid"}, core_valid_o, 1'b0);
        chk({tag, "_ct"}, ciphertext_o, '0);
        chk({tag, "_pc"}, pc_o, '0);
        chk({tag, "_busy"}, busy_o, 1'b0);
        chk({tag, "_done"}, done_o, 1'b0);
        chk({tag, "_err"}, error_o, 1'b0);
    endtask

    // one complete run of n blocks; expectations come from the block list mem[0..n-1]
    task automatic run_blocks(input int n, input bit noise);
        int c0;
        int guard;
        clear_run();
        @(negedge clk_i);
        start_i = 1'b1;
        block_count_i = n[AW:0];
        c0 = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        guard = 0;
        while (!done_o && guard < 4000) begin
            if (noise) begin
                start_i = ($urandom_range(0, 3) == 0);
                block_count_i = (AW+1)'($urandom);
            end
            @(negedge clk_i);
            guard++;
        end
        start_i = 1'b0;
        chk("run_completes", done_o, 1'b1);
        repeat (3) @(negedge clk_i);
        chk("hs_count", hs_q.size(), n);
        chk("pc_done_count", pc_q.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < hs_q.size()) chk("hs_data", hs_q[k], mem[k]);
            if (k < pc_q.size()) chk("pc_at_done", pc_q[k], k);
        end
        chk("done_pulses", done_cnt, 1);
        chk("rd_count", rd_cnt, n);
        if (n > 0) begin
            chk("done_latency", done_cyc, last_done_cyc + 2);
            chk("first_fetch_cyc", first_rd_cyc, c0 + 1);
            chk("first_issue_cyc", first_valid_cyc, c0 + 3);
        end else begin
            chk("done_cyc_cnt0", done_cyc, c0 + 1);
            chk("no_valid_cnt0", first_valid_cyc, -1);
        end
        chk("busy_after", busy_o, 1'b0);
        chk("err_after", error_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0;
        int guard;
        rst_ni = 1'b0;
        start_i = 1'b0;
        block_count_i = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        clear_run();
        repeat (3) @(negedge clk_i);
        chk_all_zero("rst");
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_all_zero("post_rst");

        // three blocks, ready tied high, finish 10 cycles after each handshake
        ready_pct = 100; lat_min = 10; lat_max = 10;
        run_blocks(3, 0);

        // zero blocks: straight to completion, no memory or core traffic
        clear_run();
        @(negedge clk_i);
        start_i = 1'b1;
        block_count_i = '0;
        c0 = cyc;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("cnt0_busy_c1", busy_o, 1'b1);
        chk("cnt0_done_c1", done_o, 1'b1);
        @(negedge clk_i);
        chk("cnt0_busy_c2", busy_o, 1'b0);
        chk("cnt0_done_c2", done_o, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("cnt0_rd", rd_cnt, 0);
        chk("cnt0_valid", first_valid_cyc, -1);
        chk("cnt0_pulses", done_cnt, 1);

        // five-cycle ready stall on every block
        stall_en = 1; lat_min = 3; lat_max = 3;
        run_blocks(2, 0);
        stall_en = 0;

        // spurious finish pulses in ISSUE plus start/count noise mid-run
        spur_en = 1; ready_pct = 40; lat_min = 2; lat_max = 8;
        run_blocks(4, 1);
        spur_en = 0;

        // asynchronous reset in WAIT_CORE of block 1, then a clean rerun
        ready_pct = 100; lat_min = 10; lat_max = 10;
        clear_run();
        @(negedge clk_i);
        start_i = 1'b1;
        block_count_i = 5'd3;
        @(negedge clk_i);
        start_i = 1'b0;
        guard = 0;
        while (hs_q.size() < 2 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        chk("rst_reach_blk1", hs_q.size(), 2);
        repeat (2) @(negedge clk_i);
        chk("pc_before_rst", pc_o, 1);
        chk("busy_before_rst", busy_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("midrun_rst");
        repeat (2) @(negedge clk_i);
        chk("no_done_on_rst", done_cnt, 0);
        rst_ni = 1'b1;
        run_blocks(3, 0);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            ready_pct = $urandom_range(30, 100);
            lat_min = 1;
            lat_max = $urandom_range(1, 12);
            spur_en = $urandom_range(0, 1) != 0;
            run_blocks($urandom_range(1, 6), $urandom_range(0, 1) != 0);
        end
        spur_en = 0;

        // full address range
        ready_pct = 70; lat_min = 1; lat_max = 3;
        run_blocks(1 << AW, 1);

`ifdef SEQ_TIMEOUT_EN
        // core never finishes: watchdog fires after TO cycles in WAIT_CORE
        ready_pct = 100;
        core_never = 1;
        clear_run();
        @(negedge clk_i);
        start_i = 1'b1;
        block_count_i = 5'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        guard = 0;
        while (hs_q.size() < 1 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        chk("to_handshake", hs_q.size(), 1);
        guard = 0;
        while (!error_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        chk("to_err_set", error_o, 1'b1);
        chk("to_err_cycle", cyc, hs_cyc + TO + 1);
        chk("to_idle", busy_o, 1'b0);
        repeat (3) @(negedge clk_i);
        chk("to_no_done", done_cnt, 0);
        chk("to_err_sticky", error_o, 1'b1);
        core_never = 0;
        @(negedge clk_i);
        start_i = 1'b1;
        block_count_i = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("to_err_cleared", error_o, 1'b0);
        repeat (2) @(negedge clk_i);
`else
        chk("err_tied_low", error_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
